ps2_rx_fifo: RTL

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

---
 rtl/ps2_rx_fifo.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised, glitch-filtered ps2_clk drives an
// 11-bit frame decoder that pushes good bytes into a first-word-fall-through FIFO.
module ps2_rx_fifo #(
    parameter int DEPTH_LOG2  = 3,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    input  logic                  rd,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic [7:0]            data,
    output logic                  ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  parity_err,
    output logic                  frame_err
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int FW    = $clog2(FILTER_LEN + 1);
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic clk_s1, clk_s2, dat_s1, dat_s2;
    logic filt;
    logic [FW-1:0] filt_cnt;
    logic filt_flip, sample;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // filt_cnt counts consecutive samples that disagree with the filtered level
    assign filt_flip = (clk_s2 != filt) && (filt_cnt == FW'(FILTER_LEN - 1));
    assign sample    = filt_flip && filt;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            filt     <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 == filt) begin
            filt_cnt <= '0;
        end else if (filt_flip) begin
            filt     <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    state_t        state, state_d;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] to_cnt;
    logic          timeout, accept, perr_set, ferr_set, par_ok;
    logic          wr_en;
    logic [7:0]    wr_byte;

    assign timeout = (state != S_IDLE) && !sample && (to_cnt == TW'(TIMEOUT_CYC - 1));
    assign par_ok  = ^{shift, par_bit};

    always_comb begin
        state_d  = state;
        accept   = 1'b0;
        perr_set = 1'b0;
        ferr_set = 1'b0;
        if (sample) begin
            case (state)
                S_IDLE:   if (!dat_s2) state_d = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_d = S_PARITY;
                S_PARITY: state_d = S_STOP;
                S_STOP: begin
                    state_d  = S_IDLE;
                    accept   = dat_s2 && par_ok;
                    perr_set = !par_ok;
                    ferr_set = !dat_s2;
                end
                default:  state_d = S_IDLE;
            endcase
        end else if (timeout) begin
            state_d  = S_IDLE;
            ferr_set = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            to_cnt  <= '0;
            wr_en   <= 1'b0;
            wr_byte <= '0;
        end else begin
            state   <= state_d;
            wr_en   <= accept;
            wr_byte <= shift;
            if (state == S_IDLE || sample) to_cnt <= '0;
            else                           to_cnt <= to_cnt + TW'(1);
            if (timeout || (sample && state == S_IDLE)) bit_cnt <= '0;
            if (sample && state == S_DATA) begin
                shift   <= {dat_s2, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (sample && state == S_PARITY) par_bit <= dat_s2;
        end
    end

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  pop, full, do_write, ovf_set;

    assign ready    = (level != '0);
    assign full     = (level == LW'(DEPTH));
    assign pop      = rd && ready;
    // at full a simultaneous pop frees the slot being overwritten
    assign do_write = wr_en && (!full || pop);
    assign ovf_set  = wr_en && full && !pop && !flush;
    assign data     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!flush && do_write) mem[wr_ptr] <= wr_byte;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)      rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            if (do_write && !pop)      level <= level + LW'(1);
            else if (!do_write && pop) level <= level - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            overflow   <= ovf_set  || (overflow   && !clr_err);
            parity_err <= perr_set || (parity_err && !clr_err);
            frame_err  <= ferr_set || (frame_err  && !clr_err);
        end
    end
endmodule
